// File: rtl/reg_ctx_mover.sv
// reg_ctx_mover: spills or restores a contiguous block of CPU registers over valid/ready streams.
// Optional macro REG_CTX_CHECKSUM_EN adds a running modulo-2^DATA_W sum of transferred words (chk_sum).
`default_nettype none

module reg_ctx_mover #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_rdaddr,
    input  logic [DATA_W-1:0] rf_rddata,
    output logic [ADDR_W-1:0] rf_wraddr,
    output logic [DATA_W-1:0] rf_wrdata,
    output logic              rf_write,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready
`ifdef REG_CTX_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_sum
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SP_RD   = 3'd1,
        SP_OUT  = 3'd2,
        RS_WAIT = 3'd3,
        RS_WR   = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic              out_hs, in_hs;

    assign out_hs = (state == SP_OUT)  && out_valid && out_ready;
    assign in_hs  = (state == RS_WAIT) && in_valid  && in_ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    state_n = mode ? RS_WAIT : SP_RD;
                end
            end
            SP_RD:  state_n = SP_OUT;
            SP_OUT: begin
                if (out_hs) begin
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = SP_RD;
                    end
                end
            end
            RS_WAIT: begin
                if (in_hs) state_n = RS_WR;
            end
            RS_WR: begin
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = RS_WAIT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status/handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_rdaddr <= '0;
            rf_wraddr <= '0;
            rf_wrdata <= '0;
            rf_write  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            busy      <= (state_n == SP_RD) || (state_n == SP_OUT) ||
                         (state_n == RS_WAIT) || (state_n == RS_WR);
            done      <= (state_n == DONE);
            out_valid <= (state_n == SP_OUT);
            in_ready  <= (state_n == RS_WAIT);
            rf_write  <= (state_n == RS_WR);
            rf_rdaddr <= idx_n;
            if (state == SP_RD) out_data <= rf_rddata;
            if (in_hs) begin
                rf_wrdata <= in_data;
                rf_wraddr <= idx;
            end
        end
    end

`ifdef REG_CTX_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sum <= '0;
        end else if (state == IDLE && start) begin
            chk_sum <= '0;
        end else if (out_hs) begin
            chk_sum <= chk_sum + out_data;
        end else if (in_hs) begin
            chk_sum <= chk_sum + in_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_ctx_mover.sv
// Randomized self-checking bench for reg_ctx_mover with a behavioural register file and transfer model.
`default_nettype none

module tb_reg_ctx_mover;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, mode, busy, done, rf_write;
    logic [AW-1:0] rf_rdaddr, rf_wraddr;
    logic [DW-1:0] rf_rddata, rf_wrdata, out_data, in_data;
    logic          out_valid, out_ready, in_valid, in_ready;
`ifdef REG_CTX_CHECKSUM_EN
    logic [DW-1:0] chk_sum;
`endif

    int errors = 0;
    int checks = 0;

    reg_ctx_mover #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy), .done(done),
        .rf_rdaddr(rf_rdaddr), .rf_rddata(rf_rddata),
        .rf_wraddr(rf_wraddr), .rf_wrdata(rf_wrdata), .rf_write(rf_write),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
`ifdef REG_CTX_CHECKSUM_EN
        , .chk_sum(chk_sum)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, clocked write, plus a bulk preload port.
    logic [DW-1:0] rf_mem   [0:(1<<AW)-1];
    logic [DW-1:0] pre_vals [NR];
    logic          pre_load;
    assign rf_rddata = rf_mem[rf_rdaddr];
    always @(posedge clk) begin
        if (pre_load) begin
            for (int i = 0; i < NR; i++) rf_mem[i] <= pre_vals[i];
        end else if (rf_write) begin
            rf_mem[rf_wraddr] <= rf_wrdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_spill(input logic [DW-1:0] w [NR], input int rdy_rand, input int stall_word, input bit poke);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] sum, prev_data, e;
        int            got, first_valid, stall_left;
        bit            prev_stall, finished;
        got = 0; first_valid = -1; stall_left = 3; prev_stall = 0; finished = 0; sum = '0; prev_data = '0;
        @(negedge clk);
        pre_vals = w; pre_load = 1'b1;
        @(negedge clk);
        pre_load = 1'b0;
        for (int i = 0; i < NR; i++) exp_q.push_back(w[i]);
        start = 1'b1; mode = 1'b0; in_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0; mode = 1'b0;
            if (prev_stall) begin
                check("spill_hold_valid", out_valid, 1);
                check("spill_hold_data", out_data, prev_data);
            end
            check("spill_busy", busy, !done);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && got == stall_word && stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else begin
                out_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
                check("spill_data", out_data, e);
                sum += out_data;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (poke && busy && ($urandom % 4) == 0) begin
                start = 1'b1; mode = 1'($urandom % 2);
            end
            if (done) begin
                check("spill_words", got, NR);
                if (!rdy_rand && stall_word < 0) begin
                    check("spill_done_lat", cyc, 2*NR+1);
                    check("spill_first_valid", first_valid, 2);
                end
`ifdef REG_CTX_CHECKSUM_EN
                check("spill_chk", chk_sum, sum);
`endif
                finished = 1;
                break;
            end
        end
        if (!finished) check("spill_timeout", 0, 1);
        start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("spill_post_done", done, 0);
        check("spill_post_busy", busy, 0);
    endtask

    task automatic do_restore(input logic [DW-1:0] w [NR], input int gappy, input bit poke);
        logic [DW-1:0] src [$];
        logic [DW-1:0] wexp [$];
        logic [DW-1:0] sum, e;
        int            nwr, first_wr;
        bit            finished;
        nwr = 0; first_wr = -1; finished = 0; sum = '0;
        for (int i = 0; i < NR; i++) src.push_back(w[i]);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; in_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0; mode = 1'b0;
            check("rs_busy", busy, !done);
            if (rf_write) begin
                if (first_wr < 0) first_wr = cyc;
                check("rs_wr_addr", rf_wraddr, nwr);
                e = (wexp.size() > 0) ? wexp.pop_front() : ~rf_wrdata;
                check("rs_wr_data", rf_wrdata, e);
                nwr++;
            end
            case (gappy)
                0:       in_valid = 1'b1;
                1:       in_valid = 1'(cyc % 2);
                default: in_valid = 1'($urandom % 2);
            endcase
            if (src.size() == 0) in_valid = 1'b0;
            in_data = (src.size() > 0) ? src[0] : DW'($urandom);
            if (in_valid && in_ready) begin
                e = src.pop_front();
                wexp.push_back(e);
                sum += e;
            end
            if (poke && busy && ($urandom % 4) == 0) begin
                start = 1'b1; mode = 1'($urandom % 2);
            end
            if (done) begin
                check("rs_writes", nwr, NR);
                if (gappy == 0) begin
                    check("rs_done_lat", cyc, 2*NR+1);
                    check("rs_first_wr", first_wr, 2);
                end
                for (int i = 0; i < NR; i++) check("rs_readback", rf_mem[i], w[i]);
`ifdef REG_CTX_CHECKSUM_EN
                check("rs_chk", chk_sum, sum);
`endif
                finished = 1;
                break;
            end
        end
        if (!finished) check("rs_timeout", 0, 1);
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rs_post_done", done, 0);
        check("rs_post_busy", busy, 0);
    endtask

    logic [DW-1:0] wv [NR];

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_data = '0; pre_load = 1'b0;
        for (int i = 0; i < NR; i++) pre_vals[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_rf_write", rf_write, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rdaddr", rf_rdaddr, 0);
`ifdef REG_CTX_CHECKSUM_EN
        check("rst_chk", chk_sum, 0);
`endif
        rst_n = 1'b1;

        wv = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_spill(wv, 0, -1, 0);
        do_spill(wv, 0, 2, 0);
        wv = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        do_restore(wv, 1, 0);
        do_restore(wv, 0, 1);
        wv = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_spill(wv, 0, -1, 1);

        // Reset while word 1 is presented on the spill stream.
        @(negedge clk);
        pre_vals = wv; pre_load = 1'b1;
        @(negedge clk);
        pre_load = 1'b0; start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        begin
            int seen = 0;
            for (int cyc = 0; cyc < 50 && seen < 2; cyc++) begin
                if (out_valid) seen++;
                if (seen < 2) @(negedge clk);
            end
            check("rst_mid_reached", seen, 2);
        end
        check("rst_mid_word1", out_data, 16'h2222);
        out_ready = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rf_write", rf_write, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        wv = '{16'h5A5A, 16'h0F0F, 16'hC3C3, 16'h1234};
        do_restore(wv, 0, 0);

`ifdef REG_CTX_CHECKSUM_EN
        wv = '{16'hFFFF, 16'h0001, 16'h0002, 16'h0003};
        do_spill(wv, 0, -1, 0);
        check("chk_fixed", chk_sum, 16'h0005);
`endif

        repeat (6) begin
            for (int i = 0; i < NR; i++) wv[i] = DW'($urandom);
            do_spill(wv, 1, int'($urandom % 5) - 1, 1);
            for (int i = 0; i < NR; i++) wv[i] = DW'($urandom);
            do_restore(wv, 2, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
